// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the front-end pipeline sequencer: FSM state encoding
// and PC redirect select codes.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    SEQ_RUN        = 2'b00,
    SEQ_BR_WAIT    = 2'b01,
    SEQ_TRAP_DRAIN = 2'b10,
    SEQ_TRAP_REDIR = 2'b11
  } seq_state_t;

  localparam logic [1:0] PC_MUX_NPC  = 2'b00;
  localparam logic [1:0] PC_MUX_BR   = 2'b01;
  localparam logic [1:0] PC_MUX_TRAP = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Decode-stage front-end controller: branch resolution wait, ECALL drain and
// mtvec redirect, plus a saturating stall counter and sticky trap error flag.
module pipeline_sequencer
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   DE_V,
  input  logic                   V_DE_BR_STALL,
  input  logic                   V_DE_TRAP_STALL,
  input  logic                   V_HAZARD_STALL,
  input  logic                   V_MEM_STALL,
  input  logic                   EXE_BR_V,
  input  logic                   EXE_BR_TAKEN,
  input  logic [XLEN-1:0]        EXE_BR_TARGET,
  input  logic [XLEN-1:0]        DE_MTVEC,
  input  logic                   WB_CS,
  output logic                   LD_PC,
  output logic [1:0]             PC_MUX,
  output logic [XLEN-1:0]        PC_TARGET,
  output logic                   LD_DE,
  output logic                   FE_DE_V,
  output logic [1:0]             SEQ_STATE,
  output logic [STALL_CNT_W-1:0] STALL_COUNT,
  output logic                   TRAP_ERR
);

  localparam int            DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  seq_state_t             state;
  logic [DW-1:0]          drain_cnt;
  logic                   trap_err_q;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic            ld_pc_c;
  logic            ld_de_c;
  logic            fe_de_v_c;
  logic [1:0]      pc_mux_c;
  logic [XLEN-1:0] pc_target_c;

  logic de_trap;
  logic de_br;
  assign de_trap = DE_V && V_DE_TRAP_STALL;
  assign de_br   = DE_V && V_DE_BR_STALL;

  // Memory stall freezes everything, so decode only acts when out of reset and unstalled.
  always_comb begin
    ld_pc_c     = 1'b0;
    ld_de_c     = 1'b0;
    fe_de_v_c   = 1'b0;
    pc_mux_c    = PC_MUX_NPC;
    pc_target_c = '0;
    if (RESET_N && !V_MEM_STALL) begin
      case (state)
        SEQ_RUN: begin
          if (!V_HAZARD_STALL) begin
            ld_de_c = 1'b1;
            if (!de_trap && !de_br) begin
              ld_pc_c   = 1'b1;
              fe_de_v_c = 1'b1;
            end
          end
        end
        SEQ_BR_WAIT: begin
          ld_de_c = 1'b1;
          if (EXE_BR_V) begin
            ld_pc_c = 1'b1;
            if (EXE_BR_TAKEN) begin
              pc_mux_c    = PC_MUX_BR;
              pc_target_c = EXE_BR_TARGET;
            end
          end
        end
        SEQ_TRAP_DRAIN: begin
          ld_de_c = 1'b1;
        end
        SEQ_TRAP_REDIR: begin
          ld_pc_c     = 1'b1;
          ld_de_c     = 1'b1;
          pc_mux_c    = PC_MUX_TRAP;
          pc_target_c = DE_MTVEC;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= SEQ_RUN;
      drain_cnt  <= '0;
      trap_err_q <= 1'b0;
    end else if (!V_MEM_STALL) begin
      if (WB_CS && (state != SEQ_TRAP_DRAIN)) begin
        trap_err_q <= 1'b1;
      end
      case (state)
        SEQ_RUN: begin
          if (!V_HAZARD_STALL) begin
            if (de_trap) begin
              drain_cnt <= DRAIN_INIT;
              state     <= SEQ_TRAP_DRAIN;
            end else if (de_br) begin
              state <= SEQ_BR_WAIT;
            end
          end
        end
        SEQ_BR_WAIT: begin
          if (EXE_BR_V) begin
            state <= SEQ_RUN;
          end
        end
        SEQ_TRAP_DRAIN: begin
          // Commit beats expiry when both land on the last drain cycle.
          if (WB_CS) begin
            drain_cnt <= '0;
            state     <= SEQ_TRAP_REDIR;
          end else if (drain_cnt <= DW'(1)) begin
            drain_cnt  <= '0;
            trap_err_q <= 1'b1;
            state      <= SEQ_TRAP_REDIR;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        SEQ_TRAP_REDIR: begin
          state <= SEQ_RUN;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .clear (!RESET_N),
    .inc   (RESET_N && !ld_pc_c),
    .count (stall_cnt)
  );

  assign LD_PC       = ld_pc_c;
  assign PC_MUX      = pc_mux_c;
  assign PC_TARGET   = pc_target_c;
  assign LD_DE       = ld_de_c;
  assign FE_DE_V     = fe_de_v_c;
  assign SEQ_STATE   = RESET_N ? state : SEQ_RUN;
  assign STALL_COUNT = RESET_N ? stall_cnt : '0;
  assign TRAP_ERR    = RESET_N && trap_err_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run, all checked against a behavioural model kept here.
module tb_pipeline_sequencer;

  // ---------------- clock ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        rst_n, de_v, br_stall, trap_stall, haz, mem, exe_v, taken, wb;
  logic [63:0] target, mtvec;

  logic        ld_pc, ld_de, fe_de_v, trap_err;
  logic [1:0]  pc_mux, seq_state;
  logic [63:0] pc_tgt;
  logic [15:0] stall_count;

  logic        ld_pc4, ld_de4, fe_de_v4, trap_err4;
  logic [1:0]  pc_mux4, seq_state4;
  logic [63:0] pc_tgt4;
  logic [3:0]  stall_count4;

  pipeline_sequencer dut (
    .CLK(clk), .RESET_N(rst_n), .DE_V(de_v), .V_DE_BR_STALL(br_stall),
    .V_DE_TRAP_STALL(trap_stall), .V_HAZARD_STALL(haz), .V_MEM_STALL(mem),
    .EXE_BR_V(exe_v), .EXE_BR_TAKEN(taken), .EXE_BR_TARGET(target),
    .DE_MTVEC(mtvec), .WB_CS(wb), .LD_PC(ld_pc), .PC_MUX(pc_mux),
    .PC_TARGET(pc_tgt), .LD_DE(ld_de), .FE_DE_V(fe_de_v),
    .SEQ_STATE(seq_state), .STALL_COUNT(stall_count), .TRAP_ERR(trap_err)
  );

  pipeline_sequencer #(.STALL_CNT_W(4)) dut4 (
    .CLK(clk), .RESET_N(rst_n), .DE_V(de_v), .V_DE_BR_STALL(br_stall),
    .V_DE_TRAP_STALL(trap_stall), .V_HAZARD_STALL(haz), .V_MEM_STALL(mem),
    .EXE_BR_V(exe_v), .EXE_BR_TAKEN(taken), .EXE_BR_TARGET(target),
    .DE_MTVEC(mtvec), .WB_CS(wb), .LD_PC(ld_pc4), .PC_MUX(pc_mux4),
    .PC_TARGET(pc_tgt4), .LD_DE(ld_de4), .FE_DE_V(fe_de_v4),
    .SEQ_STATE(seq_state4), .STALL_COUNT(stall_count4), .TRAP_ERR(trap_err4)
  );

  // ---------------- scoreboard / model ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];

  // model: pending branch, remaining drain cycles (0 = not draining), redirect due
  bit m_br, m_redir, m_err, n_br, n_redir, n_err;
  int m_drain, m_cnt, m_cnt4, n_drain, n_cnt, n_cnt4;

  logic        e_ld_pc, e_ld_de, e_fe;
  logic [1:0]  e_mux, e_state;
  logic [63:0] e_tgt;
  logic [91:0] exp_vec, obs_vec;

  // Evaluate the model for the current inputs and capture both vectors.
  task automatic settle();
    #2;
    e_ld_pc = 0; e_ld_de = 0; e_fe = 0; e_mux = 2'b00; e_tgt = '0;
    n_br = m_br; n_redir = m_redir; n_err = m_err; n_drain = m_drain;
    n_cnt = m_cnt; n_cnt4 = m_cnt4;
    if (!rst_n) begin
      n_br = 0; n_redir = 0; n_err = 0; n_drain = 0; n_cnt = 0; n_cnt4 = 0;
    end else begin
      if (!mem) begin
        if (m_redir) begin
          e_ld_pc = 1; e_ld_de = 1; e_mux = 2'b10; e_tgt = mtvec;
          n_redir = 0;
          if (wb) n_err = 1;
        end else if (m_drain > 0) begin
          e_ld_de = 1;
          if (wb) begin n_redir = 1; n_drain = 0; end
          else if (m_drain == 1) begin n_err = 1; n_redir = 1; n_drain = 0; end
          else n_drain = m_drain - 1;
        end else if (m_br) begin
          e_ld_de = 1;
          if (exe_v) begin
            e_ld_pc = 1; n_br = 0;
            if (taken) begin e_mux = 2'b01; e_tgt = target; end
          end
          if (wb) n_err = 1;
        end else begin
          if (!haz) begin
            e_ld_de = 1;
            if (de_v && trap_stall) n_drain = 4;
            else if (de_v && br_stall) n_br = 1;
            else begin e_ld_pc = 1; e_fe = 1; end
          end
          if (wb) n_err = 1;
        end
      end
      if (!e_ld_pc) begin
        if (m_cnt < 65535) n_cnt = m_cnt + 1;
        if (m_cnt4 < 15) n_cnt4 = m_cnt4 + 1;
      end
    end
    e_state = !rst_n ? 2'd0 : m_redir ? 2'd3 : (m_drain > 0) ? 2'd2 : m_br ? 2'd1 : 2'd0;
    exp_vec = {e_ld_pc, e_ld_de, e_fe, e_ld_pc ? e_mux : 2'b00, e_ld_pc ? e_tgt : 64'd0,
               e_state, rst_n ? 16'(m_cnt) : 16'd0, rst_n ? 4'(m_cnt4) : 4'd0,
               rst_n && m_err};
    obs_vec = {ld_pc, ld_de, fe_de_v & e_ld_de, e_ld_pc ? pc_mux : 2'b00,
               e_ld_pc ? pc_tgt : 64'd0, seq_state, stall_count, stall_count4, trap_err};
  endtask

  task automatic advance();
    @(posedge clk);
    m_br = n_br; m_redir = n_redir; m_err = n_err; m_drain = n_drain;
    m_cnt = n_cnt; m_cnt4 = n_cnt4;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst_n = 1; de_v = 1; br_stall = 0; trap_stall = 0; haz = 0; mem = 0;
    exe_v = 0; taken = 0; wb = 0; target = '0;
  endtask

  task automatic rand_inputs();
    de_v = 1'($urandom); br_stall = 1'($urandom); trap_stall = 1'($urandom);
    haz = 1'($urandom); mem = 1'($urandom); exe_v = 1'($urandom);
    taken = 1'($urandom); wb = 1'($urandom);
    target = {$urandom, $urandom}; mtvec = {$urandom, $urandom};
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs(); rst_n = 0;
      settle(); advance();
    end
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); rst_n = 0;
      settle();
      total_cnt++;
      if ({ld_pc, pc_mux, pc_tgt, ld_de, fe_de_v, seq_state, stall_count, trap_err} !== '0)
        $display("FAIL reset_outputs: got ld_pc=%b mux=%b tgt=%h ld_de=%b fe=%b st=%b cnt=%0d err=%b required all 0",
                 ld_pc, pc_mux, pc_tgt, ld_de, fe_de_v, seq_state, stall_count, trap_err);
      else pass_cnt++;
      advance();
    end
    idle(); settle();
    total_cnt++;
    if ({seq_state, ld_pc, fe_de_v} !== {2'b00, 1'b1, 1'b1})
      $display("FAIL reset_release: got st=%b ld_pc=%b fe=%b required 00 1 1", seq_state, ld_pc, fe_de_v);
    else pass_cnt++;
    total_cnt++;
    if (obs_vec !== exp_vec) $display("FAIL reset_vec: got %h required %h", obs_vec, exp_vec);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_taken_branch();
    do_reset(2);
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) br_stall = 1;
      if (c >= 1) de_v = 0;
      if (c == 2) begin exe_v = 1; taken = 1; target = 64'h8000_0040; end
      settle();
      total_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL taken_vec%0d: got %h required %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      if (c < 2) begin
        total_cnt++;
        if ({ld_pc, ld_de, fe_de_v} !== 3'b010)
          $display("FAIL taken_bubble%0d: got %b required 010", c, {ld_pc, ld_de, fe_de_v});
        else pass_cnt++;
      end
      if (c == 2) begin
        total_cnt++;
        if ({ld_pc, pc_mux, pc_tgt} !== {1'b1, 2'b01, 64'h8000_0040})
          $display("FAIL taken_redirect: got ld_pc=%b mux=%b tgt=%h required 1 01 80000040", ld_pc, pc_mux, pc_tgt);
        else pass_cnt++;
      end
      if (c == 3) begin
        total_cnt++;
        if ({seq_state, stall_count} !== {2'b00, 16'd2})
          $display("FAIL taken_after: got st=%b cnt=%0d required 00 2", seq_state, stall_count);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_not_taken_mem();
    do_reset(2);
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) br_stall = 1;
      if (c >= 1) begin de_v = 0; exe_v = 1; target = 64'hdead_beef; end
      if (c >= 1 && c <= 3) mem = 1;
      settle();
      total_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL nt_mem_vec%0d: got %h required %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      if (c >= 1 && c <= 3) begin
        total_cnt++;
        if ({seq_state, ld_de, ld_pc} !== {2'b01, 1'b0, 1'b0})
          $display("FAIL nt_mem_hold%0d: got st=%b ld_de=%b ld_pc=%b required 01 0 0", c, seq_state, ld_de, ld_pc);
        else pass_cnt++;
      end
      if (c == 4) begin
        total_cnt++;
        if ({ld_pc, pc_mux} !== {1'b1, 2'b00})
          $display("FAIL nt_release: got ld_pc=%b mux=%b required 1 00", ld_pc, pc_mux);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_ecall();
    do_reset(2);
    mtvec = 64'h1000;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) trap_stall = 1;
      if (c >= 1) de_v = 0;
      if (c == 3) wb = 1;
      settle();
      total_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL ecall_vec%0d: got %h required %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      if (c >= 1 && c <= 3) begin
        total_cnt++;
        if ({seq_state, ld_pc, ld_de, fe_de_v} !== 5'b10010)
          $display("FAIL ecall_drain%0d: got %b required 10010", c, {seq_state, ld_pc, ld_de, fe_de_v});
        else pass_cnt++;
      end
      if (c == 4) begin
        total_cnt++;
        if ({seq_state, ld_pc, pc_mux, pc_tgt} !== {2'b11, 1'b1, 2'b10, 64'h1000})
          $display("FAIL ecall_redir: got st=%b ld_pc=%b mux=%b tgt=%h required 11 1 10 1000",
                   seq_state, ld_pc, pc_mux, pc_tgt);
        else pass_cnt++;
      end
      if (c == 5) begin
        total_cnt++;
        if ({seq_state, trap_err} !== 3'b000)
          $display("FAIL ecall_done: got st=%b err=%b required 00 0", seq_state, trap_err);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_trap_timeout();
    do_reset(2);
    mtvec = 64'h2000;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c == 0 || c == 6) trap_stall = 1;
      if (c == 7) wb = 1;
      settle();
      total_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL timeout_vec%0d: got %h required %h", c, obs_vec, exp_vec);
      else pass_cnt++;
      if (c >= 1 && c <= 4) begin
        total_cnt++;
        if (seq_state !== 2'b10) $display("FAIL timeout_drain%0d: got %b required 10", c, seq_state);
        else pass_cnt++;
      end
      if (c == 5) begin
        total_cnt++;
        if ({seq_state, pc_mux, trap_err} !== {2'b11, 2'b10, 1'b1})
          $display("FAIL timeout_redir: got st=%b mux=%b err=%b required 11 10 1", seq_state, pc_mux, trap_err);
        else pass_cnt++;
      end
      if (c == 9) begin
        total_cnt++;
        if ({seq_state, trap_err} !== 3'b001)
          $display("FAIL timeout_sticky: got st=%b err=%b required 00 1", seq_state, trap_err);
        else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_priority_sat();
    do_reset(2);
    idle(); haz = 1; trap_stall = 1; br_stall = 1;
    settle();
    total_cnt++;
    if ({ld_pc, ld_de} !== 2'b00) $display("FAIL prio_hold: got %b required 00", {ld_pc, ld_de});
    else pass_cnt++;
    advance();
    haz = 0;
    settle();
    total_cnt++;
    if ({seq_state, ld_pc, ld_de, fe_de_v} !== 5'b00010)
      $display("FAIL prio_trap: got %b required 00010", {seq_state, ld_pc, ld_de, fe_de_v});
    else pass_cnt++;
    advance();
    idle(); settle();
    total_cnt++;
    if (seq_state !== 2'b10) $display("FAIL prio_state: got %b required 10", seq_state);
    else pass_cnt++;
    advance();
    do_reset(2);
    haz = 1;
    for (int i = 0; i < 20; i++) begin settle(); advance(); end
    settle();
    total_cnt++;
    if ({stall_count, stall_count4} !== {16'd20, 4'd15})
      $display("FAIL sat_count: got cnt=%0d cnt4=%0d required 20 15", stall_count, stall_count4);
    else pass_cnt++;
    advance();
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 49) != 0);
      de_v = ($urandom_range(0, 4) != 0);
      trap_stall = ($urandom_range(0, 9) == 0);
      br_stall = ($urandom_range(0, 4) == 0);
      haz = ($urandom_range(0, 6) == 0);
      mem = ($urandom_range(0, 6) == 0);
      wb = ($urandom_range(0, 11) == 0);
      settle();
      if (e_ld_pc && e_mux != 2'b00) exp_q.push_back(e_tgt);
      total_cnt++;
      if (obs_vec !== exp_vec) $display("FAIL rand_vec%0d: got %h required %h", i, obs_vec, exp_vec);
      else pass_cnt++;
      if (ld_pc && pc_mux != 2'b00) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL rand_redirect%0d: got tgt=%h required no redirect", i, pc_tgt);
        else begin
          logic [63:0] want;
          want = exp_q.pop_front();
          if (pc_tgt !== want) $display("FAIL rand_redirect%0d: got %h required %h", i, pc_tgt, want);
          else pass_cnt++;
        end
      end
      advance();
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rand_queue: got %0d pending redirects required 0", exp_q.size());
    else pass_cnt++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 0; mtvec = '0;
    rand_inputs(); rst_n = 0;
    m_br = 0; m_redir = 0; m_err = 0; m_drain = 0; m_cnt = 0; m_cnt4 = 0;
    @(negedge clk);
    test_reset();
    test_taken_branch();
    test_not_taken_mem();
    test_ecall();
    test_trap_timeout();
    test_priority_sat();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
